// File: rtl/register_file.sv
// 32 x 32-bit integer register file: two combinational read ports, one write port, x0 hardwired to zero.
// Latency: reads are combinational; a write lands on the rising clk edge and is visible right after it.
// Backpressure: none, every write is accepted. Optional RF_BYPASS_EN forwards write_data to matching reads.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];

    // An X/Z write_enable fails the === compare, so an unknown strobe never writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if ((write_enable === 1'b1) && (write_reg != '0)) begin
            regs[write_reg] <= write_data;
        end
    end

`ifdef RF_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = reset && write_enable && (write_reg != '0);
`endif

    always_comb begin
        read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
        read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
`ifdef RF_BYPASS_EN
        if (fwd_ok && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end
        if (fwd_ok && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed reset/fill/x0/bypass/async-reset sequences, a vector table, and random traffic vs an array model.
module tb_register_file;

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data1, read_data2;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model [0:31];

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [7];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .write_reg    (write_reg),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Value a read port should show right now, from the architectural rules.
    function automatic logic [31:0] expect_rd(input logic [4:0] idx);
        if (!reset) return 32'h0;
        if (BYPASS && write_enable && write_reg != 5'd0 && write_reg == idx) return write_data;
        if (idx == 5'd0) return 32'h0;
        return model[idx];
    endfunction

    function automatic void model_commit();
        if (reset && write_enable && write_reg != 5'd0) model[write_reg] = write_data;
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write_reg = a; write_data = d; write_enable = 1'b1;
        clock_edge();
        write_enable = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
        tbl[1] = '{1'b0, 5'd5,  32'h12345678, 5'd5,  5'd5,  32'h5,        32'h5};
        tbl[2] = '{1'b1, 5'd3,  32'h11111111, 5'd3,  5'd4,  32'h11111111, 32'h4};
        tbl[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
        tbl[4] = '{1'b0, 5'd31, 32'h00000000, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h1E};
        tbl[5] = '{1'b1, 5'd1,  32'h80000000, 5'd1,  5'd31, 32'h80000000, 32'hFFFFFFFF};
        tbl[6] = '{1'b0, 5'd2,  32'hCAFEF00D, 5'd2,  5'd3,  32'h2,        32'h11111111};

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b0; write_enable = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = 5'd0; read_reg2 = 5'd1;

        // Reset held for two cycles, then released between edges
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_rd1", read_data1, 32'h0);
        check("reset_hold_rd2", read_data2, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_rel_rd1", read_data1, 32'h0);
        check("reset_rel_rd2", read_data2, 32'h0);

        // Sequential fill then sweep
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i));
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            #1;
            check($sformatf("fill_sweep[%0d]", i), read_data1, (i == 0) ? 32'h0 : 32'(i));
        end

        // Vector table, checked after the edge
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            write_enable = tbl[k].we; write_reg = tbl[k].wreg; write_data = tbl[k].wdata;
            read_reg1 = tbl[k].r1; read_reg2 = tbl[k].r2;
            clock_edge();
            check($sformatf("tbl[%0d].rd1", k), read_data1, tbl[k].e1);
            check($sformatf("tbl[%0d].rd2", k), read_data2, tbl[k].e2);
        end
        write_enable = 1'b0;

        // Write disabled over several edges
        @(negedge clk);
        write_enable = 1'b0; write_reg = 5'd5; write_data = 32'h12345678; read_reg1 = 5'd5;
        repeat (3) clock_edge();
        check("we0_hold_r5", read_data1, 32'h5);

        // Dual read and same-cycle read/write of index 7
        @(negedge clk);
        read_reg1 = 5'd7; read_reg2 = 5'd7;
        #1;
        check("dual_rd1_r7", read_data1, 32'h7);
        check("dual_rd2_r7", read_data2, 32'h7);
        write_reg = 5'd7; write_data = 32'hA5A5A5A5; write_enable = 1'b1;
        #1;
        check("same_cyc_pre_rd1", read_data1, BYPASS ? 32'hA5A5A5A5 : 32'h7);
        check("same_cyc_pre_rd2", read_data2, BYPASS ? 32'hA5A5A5A5 : 32'h7);
        clock_edge();
        write_enable = 1'b0;
        #1;
        check("same_cyc_post_rd1", read_data1, 32'hA5A5A5A5);
        check("same_cyc_post_rd2", read_data2, 32'hA5A5A5A5);

        // Asynchronous reset between edges, write attempted during reset
        read_reg1 = 5'd7; read_reg2 = 5'd31;
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        check("async_rst_rd1", read_data1, 32'h0);
        check("async_rst_rd2", read_data2, 32'h0);
        write_reg = 5'd9; write_data = 32'h99999999; write_enable = 1'b1; read_reg1 = 5'd9;
        clock_edge();
        check("wr_during_rst", read_data1, 32'h0);
        @(negedge clk);
        write_enable = 1'b0;
        reset = 1'b1;
        clock_edge();
        check("post_rel_no_wr", read_data1, 32'h0);
        do_write(5'd9, 32'h99999999);
        check("first_wr_after_rel", read_data1, 32'h99999999);

        // Random traffic against the array model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            write_enable = ($urandom_range(0, 3) != 0);
            write_reg    = 5'($urandom_range(0, 31));
            write_data   = $urandom;
            read_reg1    = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2    = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            #1;
            check("rand_pre_rd1", read_data1, expect_rd(read_reg1));
            check("rand_pre_rd2", read_data2, expect_rd(read_reg2));
            clock_edge();
            check("rand_post_rd1", read_data1, expect_rd(read_reg1));
            check("rand_post_rd2", read_data2, expect_rd(read_reg2));
        end
        write_enable = 1'b0;

        // Final full sweep on both ports
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            check("final_rd1", read_data1, expect_rd(read_reg1));
            check("final_rd2", read_data2, expect_rd(read_reg2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose integer register file for the processor datapath: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Sits between the decode stage (source/destination register indices) and the execute/writeback stages (operands and write-back data).
- Register 0 is hardwired to zero, matching RISC-V x0 semantics.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, width of register index ports; number of registers is 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- read_reg1  input  ADDR_WIDTH  index for read port 1.
- read_reg2  input  ADDR_WIDTH  index for read port 2.
- write_reg  input  ADDR_WIDTH  index for the write port.
- write_enable  input  1  write strobe, sampled on the rising edge of clk.
- write_data  input  DATA_WIDTH  data written to write_reg.
- read_data1  output  DATA_WIDTH  contents of register read_reg1.
- read_data2  output  DATA_WIDTH  contents of register read_reg2.

Behaviour:
- Interface: one clock domain (clk); reset is asynchronous and active-low.
- Reset: when reset = 0, all 32 registers clear to 0 immediately, independent of clk.
  - While reset is held low, writes are ignored.
  - Both read outputs therefore read 0 during reset.
- Write:
  - On the rising edge of clk with reset = 1 and write_enable = 1, register[write_reg] <= write_data.
  - Latency is one edge; the new value is visible on the read ports after that edge.
- write_enable = 0: no register changes, whatever the values of write_reg and write_data.
- Register 0:
  - Writes to index 0 are discarded.
  - read_data1 and read_data2 always return 0 when their index is 0.
- Reads:
  - Purely combinational; read_data1 = register[read_reg1] and read_data2 = register[read_reg2].
  - Outputs update in the same delta as an index change; no clock is needed.
- Both read ports may address the same register simultaneously; each returns the same value.
- Read and write of the same index in the same cycle (bypass macro absent): the read returns the old value until the clock edge, and the new value after it.
- Reset deasserted mid-cycle: registers stay 0 until the first qualifying rising edge after reset returns to 1.
- Reset asserted mid-operation: any pending write is abandoned and registers clear at once.
- Indices are always in range (5 bits cover all 32 entries); there is no wrap or error condition.
- X/Z on write_enable while reset = 1: treat as no write. Simulation-only, not synthesized.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding. When write_enable = 1, reset = 1, write_reg != 0 and write_reg equals read_regN, read_dataN returns write_data combinationally in the same cycle, before the clock edge. Applies independently to each read port.
- Not defined: no forwarding. Reads always reflect stored contents, as described under Behaviour.

Test Plan:
- Reset: drive reset = 0 for 2 cycles, then 1; set read_reg1 = 0, read_reg2 = 1 -> read_data1 = 0x0, read_data2 = 0x0.
- Sequential fill: for i = 0..31 write write_data = i with write_enable = 1 for one edge, then 0; afterwards sweep read_reg1 = 0..31 -> read_data1 = i for every i (register 0 reads 0).
- Register 0 write: write 0xDEADBEEF to index 0 -> read_data1 at index 0 = 0x0.
- Write disabled: write_enable = 0, write_reg = 5, write_data = 0x12345678, clock several edges -> register 5 keeps its prior value.
- Dual read and same-cycle access: read_reg1 = read_reg2 = 7 -> both outputs equal register 7. Write 0xA5A5A5A5 to index 7 -> before the edge, outputs show the old value (or 0xA5A5A5A5 with RF_BYPASS_EN defined); after the edge, both show 0xA5A5A5A5.
- Asynchronous reset mid-run: after the fill, pulse reset = 0 between clock edges -> all reads immediately 0. A write attempted during reset is ignored; the first write after release takes effect.
